// File: rtl/pong_pkg.sv
// Shared ids, FSM state encoding and default tone constants for the pong sound scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  // Sound source ids, also the value driven on active_id.
  typedef enum logic [1:0] {
    SND_NONE   = 2'd0,
    SND_WALL   = 2'd1,
    SND_PADDLE = 2'd2,
    SND_SCORE  = 2'd3
  } snd_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } snd_state_t;

  // Half-periods in clocks at 25.175 MHz, durations in video frames.
  localparam int unsigned DEF_WALL_HALF     = 12844;
  localparam int unsigned DEF_PADDLE_HALF   = 25689;
  localparam int unsigned DEF_SCORE_HALF    = 51378;
  localparam int unsigned DEF_WALL_FRAMES   = 2;
  localparam int unsigned DEF_PADDLE_FRAMES = 4;
  localparam int unsigned DEF_SCORE_FRAMES  = 16;
  localparam int unsigned DEF_DIV_W         = 16;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed to hold the value v itself.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pong_tone_gen.sv
// Square-wave generator: loadable half-period down-counter plus output toggle flop.
// Latency: output goes high on the load edge, then toggles every (i_half_m1+1) run clocks.
// Backpressure: none; clear beats load, load beats run.
//
// Ports:
//   clk, nRst   clock, asynchronous active-low reset
//   i_load      start a tone: latch i_half_m1 as reload value, output high
//   i_clear     stop: counter and output to 0
//   i_run       advance the divider by one clock
//   i_half_m1   half-period minus one, sampled on i_load
//   o_sound     square-wave output
module pong_tone_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_half_m1,
  output logic             o_sound
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_reload;
  logic             r_sound;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt    <= '0;
      r_reload <= '0;
      r_sound  <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_reload <= '0;
      r_sound  <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_half_m1;
      r_reload <= i_half_m1;
      r_sound  <= 1'b1;
    end else if (i_run) begin
      // Reload-at-zero gives exactly (half_m1+1) clocks per output level.
      if (r_cnt == '0) begin
        r_cnt   <= r_reload;
        r_sound <= ~r_sound;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_sound = r_sound;

endmodule

// File: rtl/pong_sound_sched.sv
// Pong sound scheduler: arbitrates wall/paddle/score events onto one square-wave output,
// Latency: req pulse -> pending at next edge -> tone starts one edge later (2 clocks).
// Backpressure: requests are held in sticky pending bits; a busy output just defers them.
//
// Optional feature macro: PONG_SOUND_PREEMPT_EN (higher-priority pending request
// cuts into a playing tone; the cut tone is dropped).
//
// Ports:
//   clk, nRst          clock, asynchronous active-low reset
//   en                 design enable; low returns to reset values (vblank edge tracker excepted)
//   vblank             vertical blank level; rising edge is the frame tick
//   req_wall/paddle/score  single-cycle event pulses
//   sound_out          square-wave audio
//   busy               high while a tone plays
//   active_id          0 none, 1 wall, 2 paddle, 3 score
module pong_sound_sched
  import pong_pkg::*;
#(
  parameter int unsigned WALL_HALF     = DEF_WALL_HALF,
  parameter int unsigned PADDLE_HALF   = DEF_PADDLE_HALF,
  parameter int unsigned SCORE_HALF    = DEF_SCORE_HALF,
  parameter int unsigned WALL_FRAMES   = DEF_WALL_FRAMES,
  parameter int unsigned PADDLE_FRAMES = DEF_PADDLE_FRAMES,
  parameter int unsigned SCORE_FRAMES  = DEF_SCORE_FRAMES,
  parameter int unsigned DIV_W         = DEF_DIV_W
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en,
  input  logic       vblank,
  input  logic       req_wall,
  input  logic       req_paddle,
  input  logic       req_score,
  output logic       sound_out,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam int unsigned FRM_W = cnt_w(max3(WALL_FRAMES, PADDLE_FRAMES, SCORE_FRAMES));

  localparam logic [DIV_W-1:0] WALL_M1   = DIV_W'(WALL_HALF - 1);
  localparam logic [DIV_W-1:0] PADDLE_M1 = DIV_W'(PADDLE_HALF - 1);
  localparam logic [DIV_W-1:0] SCORE_M1  = DIV_W'(SCORE_HALF - 1);
  localparam logic [FRM_W-1:0] WALL_FR   = FRM_W'(WALL_FRAMES);
  localparam logic [FRM_W-1:0] PADDLE_FR = FRM_W'(PADDLE_FRAMES);
  localparam logic [FRM_W-1:0] SCORE_FR  = FRM_W'(SCORE_FRAMES);
  localparam logic [FRM_W-1:0] FRM_ONE   = FRM_W'(1);

  // Pending bit order: [0] wall, [1] paddle, [2] score.
  logic [2:0]       r_pend;
  snd_state_t       r_state;
  snd_id_t          r_active_id;
  logic             r_busy;
  logic [FRM_W-1:0] r_frames;
  logic             r_vblank_q;

  logic [2:0]       w_req;
  logic             w_tick;
  snd_id_t          w_gnt_id;
  logic [2:0]       w_gnt_mask;
  logic [DIV_W-1:0] w_gnt_half_m1;
  logic [FRM_W-1:0] w_gnt_frames;
  logic             w_preempt;

  snd_state_t       w_state_nxt;
  snd_id_t          w_id_nxt;
  logic             w_busy_nxt;
  logic [FRM_W-1:0] w_frames_nxt;
  logic [2:0]       w_pend_clr;
  logic [2:0]       w_pend_nxt;
  logic             w_tone_load;
  logic             w_tone_clear;
  logic             w_tone_run;
  logic             w_sound;

  assign w_req  = {req_score, req_paddle, req_wall};
  assign w_tick = vblank & ~r_vblank_q;

  // Fixed priority: score > paddle > wall.
  always_comb begin
    w_gnt_id      = SND_NONE;
    w_gnt_mask    = 3'b000;
    w_gnt_half_m1 = WALL_M1;
    w_gnt_frames  = WALL_FR;
    if (r_pend[2]) begin
      w_gnt_id      = SND_SCORE;
      w_gnt_mask    = 3'b100;
      w_gnt_half_m1 = SCORE_M1;
      w_gnt_frames  = SCORE_FR;
    end else if (r_pend[1]) begin
      w_gnt_id      = SND_PADDLE;
      w_gnt_mask    = 3'b010;
      w_gnt_half_m1 = PADDLE_M1;
      w_gnt_frames  = PADDLE_FR;
    end else if (r_pend[0]) begin
      w_gnt_id      = SND_WALL;
      w_gnt_mask    = 3'b001;
      w_gnt_half_m1 = WALL_M1;
      w_gnt_frames  = WALL_FR;
    end
  end

`ifdef PONG_SOUND_PREEMPT_EN
  // Ids are numbered in priority order, so a numeric compare is a priority compare.
  assign w_preempt = (r_state == ST_PLAY) && (w_gnt_id > r_active_id);
`else
  assign w_preempt = 1'b0;
`endif

  // Next-state and control. A grant (from IDLE or by preemption) beats the frame tick,
  // so a tick landing on the grant edge is never counted against the new tone.
  always_comb begin
    w_state_nxt  = r_state;
    w_id_nxt     = r_active_id;
    w_busy_nxt   = r_busy;
    w_frames_nxt = r_frames;
    w_pend_clr   = 3'b000;
    w_tone_load  = 1'b0;
    w_tone_clear = 1'b0;
    if (!en) begin
      w_state_nxt  = ST_IDLE;
      w_id_nxt     = SND_NONE;
      w_busy_nxt   = 1'b0;
      w_frames_nxt = '0;
      w_tone_clear = 1'b1;
    end else if (((r_state == ST_IDLE) || w_preempt) && (w_gnt_id != SND_NONE)) begin
      w_state_nxt  = ST_PLAY;
      w_id_nxt     = w_gnt_id;
      w_busy_nxt   = 1'b1;
      w_frames_nxt = w_gnt_frames;
      w_pend_clr   = w_gnt_mask;
      w_tone_load  = 1'b1;
    end else if ((r_state == ST_PLAY) && w_tick) begin
      if (r_frames == FRM_ONE) begin
        w_state_nxt  = ST_IDLE;
        w_id_nxt     = SND_NONE;
        w_busy_nxt   = 1'b0;
        w_frames_nxt = '0;
        w_tone_clear = 1'b1;
      end else begin
        w_frames_nxt = r_frames - FRM_ONE;
      end
    end
  end

  // Set wins over clear: a new pulse on the grant cycle re-arms the same source.
  assign w_pend_nxt = en ? ((r_pend & ~w_pend_clr) | w_req) : 3'b000;
  assign w_tone_run = (r_state == ST_PLAY);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= ST_IDLE;
      r_active_id <= SND_NONE;
      r_busy      <= 1'b0;
      r_frames    <= '0;
      r_pend      <= 3'b000;
    end else begin
      r_state     <= w_state_nxt;
      r_active_id <= w_id_nxt;
      r_busy      <= w_busy_nxt;
      r_frames    <= w_frames_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  // Edge tracker keeps following vblank while disabled, so re-enabling mid-blank
  // does not fabricate a frame tick.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_vblank_q <= 1'b0;
    end else begin
      r_vblank_q <= vblank;
    end
  end

  pong_tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone (
    .clk       (clk),
    .nRst      (nRst),
    .i_load    (w_tone_load),
    .i_clear   (w_tone_clear),
    .i_run     (w_tone_run),
    .i_half_m1 (w_gnt_half_m1),
    .o_sound   (w_sound)
  );

  assign sound_out = w_sound;
  assign busy      = r_busy;
  assign active_id = r_active_id;

endmodule

// File: doc/pong_sound_sched.md
# pong_sound_sched

Arbitrates the single pong sound output between three game-event requesters (wall bounce, paddle hit, score) and sequences each request as a fixed-pitch square-wave tone lasting a fixed number of video frames. It sits between the game-logic event pulses and the `sound_out` pin. Frame timing comes from the VGA timing generator's `vblank`.

## Interface
- `WALL_HALF`, 12844: tone half-period in clocks for wall bounce (~980 Hz at 25.175 MHz)
- `PADDLE_HALF`, 25689: half-period for paddle hit (~490 Hz)
- `SCORE_HALF`, 51378: half-period for score (~245 Hz)
- `WALL_FRAMES`, 2: wall tone duration in frames; must be ≥1
- `PADDLE_FRAMES`, 4: paddle tone duration in frames; must be ≥1
- `SCORE_FRAMES`, 16: score tone duration in frames; must be ≥1
- `DIV_W`, 16: half-period counter width; every `*_HALF` must satisfy 2 ≤ `*_HALF` ≤ 2^DIV_W
- `clk`  in  1  system/pixel clock
- `nRst`  in  1  asynchronous, active-low reset
- `en`  in  1  design enable
- `vblank`  in  1  vertical blank level from VGA timing
- `req_wall`  in  1  single-cycle wall-bounce event pulse
- `req_paddle`  in  1  single-cycle paddle-hit event pulse
- `req_score`  in  1  single-cycle score event pulse
- `sound_out`  out  1  square-wave audio
- `busy`  out  1  high while a tone is playing
- `active_id`  out  2  0 = none, 1 = wall, 2 = paddle, 3 = score

## Operation
- Reset: `sound_out`=0, `busy`=0, `active_id`=0, all pending bits clear, state IDLE, `vblank_q`=0.
- Each requester has a sticky pending bit, set by its req pulse and cleared when that request is granted. If set and clear occur in the same cycle, set wins.
- Priority: score > paddle > wall.
- FSM IDLE: if any pending bit is set, grant the highest. Clear its pending bit, set `active_id`, set `sound_out`=1, load the divider with HALF−1, load the frame counter with FRAMES, and go to PLAY.
- FSM PLAY, divider: decrements each clock. At 0 it reloads HALF−1 and toggles `sound_out`.
- FSM PLAY, frames: a frame tick is `vblank & ~vblank_q`. Each tick decrements the frame counter. A tick with the counter at 1 forces `sound_out`=0, `active_id`=0, state IDLE. IDLE lasts at least one cycle before the next grant.
- A request from the currently playing source sets its pending bit. The tone replays after the current one ends.
- `en` low: synchronous return to the reset values, except `vblank_q`, which keeps tracking. Req pulses are ignored while `en` is low.

## Timing
- Req pulse sampled at edge E0 sets pending. At E1 (IDLE) `busy`=1 and `sound_out`=1. Start latency is 2 clocks.
- `sound_out` toggles every HALF clocks, so the period is 2·HALF clocks.
- A tone started mid-frame lasts until the FRAMES-th vblank rising edge after the grant. The first frame is therefore partial.
- A vblank rising edge on the grant cycle is not counted.
- `busy` and `active_id` are registered and change on the same edge as the state.

## Configuration
- `PONG_SOUND_PREEMPT_EN` defined: in PLAY, a pending bit of strictly higher priority than `active_id` is granted immediately, exactly as in IDLE, without passing through IDLE (1-clock latency from pending). The preempted tone is dropped, not re-queued.
- Not defined: a playing tone always runs to completion. Higher-priority requests wait in pending.

## Structure
- Shared package `pong_pkg`:
  - sound id constants (NONE/WALL/PADDLE/SCORE = 0..3)
  - FSM state encoding
  - default half-period and frame constants
- Sub-module `pong_tone_gen`: the loadable half-period down-counter plus `sound_out` toggle flop, with load/clear inputs.
- Arbitration, pending bits, frame counter and FSM stay in `pong_sound_sched`.

## Test plan
All scenarios use WALL_HALF=3, PADDLE_HALF=5, SCORE_HALF=7, WALL_FRAMES=2, PADDLE_FRAMES=3, SCORE_FRAMES=4, and a vblank rising edge every 100 clocks.
- Reset mid-tone: assert `nRst` low while `busy` is high -> all outputs 0 immediately; after release, no tone without a new req.
- Single wall req -> `sound_out` high 2 clocks later, toggling every 3 clocks. `busy` drops on the 2nd vblank rising edge after the grant; `active_id`=1 while busy.
- Simultaneous `req_wall`, `req_paddle`, `req_score` in IDLE -> played in order score(3), paddle(2), wall(1), each with its own half-period and duration, with exactly one IDLE cycle between tones.
- Paddle req during a wall tone, macro undefined -> wall completes, then paddle plays. With the macro defined -> within 2 clocks `active_id`=2 and the half-period is 5, and the wall tone never resumes.
- Drop `en` for 1 cycle during a tone with wall pending -> outputs and pending cleared. A `req_score` issued while `en` is low produces no tone.
- Repeated `req_paddle` during a paddle tone -> exactly one replay of the paddle tone after the first completes.
